ovl_width_multi: RTL and testbench

OVL_WIDTH_MULTI -- requirements
Module: ovl_width_multi

---
 rtl/ovl_width_multi.sv | 184 ++++++++++++++++++
 tb/tb_ovl_width_multi.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ovl_width_multi.sv
// ---------------------------------------------------------------------------
// ovl_width_multi
//
// Multi-channel pulse-width checker. Each bit of test_expr is watched on its
// own. The checker measures every high pulse in clock samples. It flags a
// pulse that ends before MIN_CKS samples, and a pulse that is still high
// after MAX_CKS samples. Setting either bound to 0 turns that check off.
// All violation outputs are registered and assert one cycle after the
// sample that caused them.
//
// Optional feature: define OVL_WIDTH_COVER_EN to add coverage logic. With
// it, fire[2] pulses after every legal completed pulse, and the extra port
// cov_count counts those pulses across all channels.
//
// Ports
//   clock      in   rising-edge clock for all state
//   reset      in   asynchronous, active-low reset
//   enable     in   global enable; low drops every channel to IDLE and
//                   discards any pulse in progress
//   test_expr  in   [NUM_CH] monitored signals
//   fire_min   out  [NUM_CH] one-cycle minimum-width violation pulses
//   fire_max   out  [NUM_CH] one-cycle maximum-width violation pulses
//   fire       out  [3]   [0] any violation, [1] reserved (0), [2] cover
//   cov_count  out  [16]  legal pulse count, saturating
//                         (present only with OVL_WIDTH_COVER_EN)
// ---------------------------------------------------------------------------
module ovl_width_multi #(
  parameter int NUM_CH  = 4,
  parameter int MIN_CKS = 1,
  parameter int MAX_CKS = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] test_expr,
  output logic [NUM_CH-1:0] fire_min,
  output logic [NUM_CH-1:0] fire_max,
  output logic [2:0]        fire
`ifdef OVL_WIDTH_COVER_EN
  ,
  output logic [15:0]       cov_count
`endif
);

  // The counter must hold MAX_CKS+1 without wrapping. That lets a pulse
  // longer than MAX_CKS be told apart from one that is exactly MAX_CKS long.
  localparam int MAX_OF = (MIN_CKS > MAX_CKS) ? MIN_CKS : MAX_CKS;
  localparam int CNT_W  = $clog2(MAX_OF + 2);

  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_CKS);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_CKS);
  localparam bit               MIN_EN  = (MIN_CKS != 0);
  localparam bit               MAX_EN  = (MAX_CKS != 0);

  // Configuration sanity checks, evaluated at elaboration.
  if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
    $error("ovl_width_multi: NUM_CH must be in 1..32");
  end
  if (MIN_CKS < 0 || MAX_CKS < 0) begin : g_bad_sign
    $error("ovl_width_multi: MIN_CKS and MAX_CKS must be non-negative");
  end
  if (MAX_CKS != 0 && MAX_CKS < MIN_CKS) begin : g_bad_range
    $error("ovl_width_multi: nonzero MAX_CKS must not be below MIN_CKS");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HIGH = 1'b1
  } state_t;

  state_t           state_q [NUM_CH];
  logic [CNT_W-1:0] cnt_q   [NUM_CH];

  logic [NUM_CH-1:0] min_set;
  logic [NUM_CH-1:0] max_set;
  logic              fire0_q;

  // Violation detection, one cycle ahead of the registered outputs.
  // cnt_q holds the number of high samples seen so far in this pulse.
  // On the falling sample it is the completed width. While the input stays
  // high, cnt_q == MAX_C marks the sample that makes the pulse too long.
  // The counter saturates above MAX_C, so that equality holds at most once
  // per pulse.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    min_set = '0;
    max_set = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (enable && state_q[i] == ST_HIGH) begin
        if (test_expr[i]) begin
          max_set[i] = MAX_EN && (cnt_q[i] == MAX_C);
        end else begin
          min_set[i] = MIN_EN && (cnt_q[i] < MIN_C);
        end
      end
    end
  end

  // Per-channel FSM and counter, plus the registered violation outputs.
  // NOTE: this is state, so it uses non-blocking assignments only; every
  // flop samples the values from before the edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the per-channel counters are control state, not a data store,
      // so they are reset along with the FSMs.
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      fire_min <= '0;
      fire_max <= '0;
      fire0_q  <= 1'b0;
    end else begin
      fire_min <= min_set;
      fire_max <= max_set;
      fire0_q  <= |(min_set | max_set);
      for (int i = 0; i < NUM_CH; i++) begin
        if (!enable) begin
          state_q[i] <= ST_IDLE;
          cnt_q[i]   <= '0;
        end else if (state_q[i] == ST_IDLE) begin
          // A rise is only seen from IDLE. After a falling sample the
          // channel spends at least one sample in IDLE before it can
          // start a new pulse.
          if (test_expr[i]) begin
            state_q[i] <= ST_HIGH;
            cnt_q[i]   <= CNT_ONE;
          end
        end else begin
          if (test_expr[i]) begin
            if (cnt_q[i] != CNT_SAT) begin
              cnt_q[i] <= cnt_q[i] + CNT_ONE;
            end
          end else begin
            state_q[i] <= ST_IDLE;
            cnt_q[i]   <= '0;
          end
        end
      end
    end
  end

`ifdef OVL_WIDTH_COVER_EN
  // A completed pulse is legal when it broke neither bound. A width above
  // MAX_C means fire_max was raised earlier in the same pulse.
  logic [NUM_CH-1:0] done_ok;
  logic [16:0]       cov_sum;
  logic              cov_fire_q;

  always_comb begin
    done_ok = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (enable && state_q[i] == ST_HIGH && !test_expr[i]) begin
        done_ok[i] = !(MIN_EN && (cnt_q[i] < MIN_C)) &&
                     !(MAX_EN && (cnt_q[i] > MAX_C));
      end
    end
  end

  // Several channels can complete in the same cycle. Each one adds to the
  // count, and the extra top bit catches overflow for saturation.
  always_comb begin
    cov_sum = {1'b0, cov_count} + 17'($countones(done_ok));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cov_count  <= '0;
      cov_fire_q <= 1'b0;
    end else begin
      cov_fire_q <= |done_ok;
      cov_count  <= cov_sum[16] ? 16'hFFFF : cov_sum[15:0];
    end
  end

  assign fire = {cov_fire_q, 1'b0, fire0_q};
`else
  assign fire = {1'b0, 1'b0, fire0_q};
`endif

endmodule

// File: tb/tb_ovl_width_multi.sv
// ---------------------------------------------------------------------------
// tb_ovl_width_multi
//
// Bench for ovl_width_multi with three configurations side by side:
//   a: NUM_CH=4, MIN=2, MAX=3
//   b: NUM_CH=1, MIN=2, MAX=2
//   c: NUM_CH=1, MIN=0, MAX=0 (both checks off)
// The reference model sees each channel as a run length of high samples.
// A run that ends shorter than MIN is a min violation. Max fires on the
// sample where the run reaches MAX+1. A run that ends inside the bounds is
// a legal (covered) pulse.
// ---------------------------------------------------------------------------
module tb_ovl_width_multi;

`ifdef OVL_WIDTH_COVER_EN
  localparam bit COV = 1'b1;
`else
  localparam bit COV = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic       enable;
  logic [3:0] te_a;
  logic [0:0] te_b;
  logic [0:0] te_c;
  logic [3:0] fmin_a, fmax_a;
  logic [0:0] fmin_b, fmax_b, fmin_c, fmax_c;
  logic [2:0] fire_a, fire_b, fire_c;
`ifdef OVL_WIDTH_COVER_EN
  logic [15:0] cov_a, cov_b, cov_c;
`endif

  ovl_width_multi #(.NUM_CH(4), .MIN_CKS(2), .MAX_CKS(3)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .test_expr(te_a),
    .fire_min(fmin_a), .fire_max(fmax_a), .fire(fire_a)
`ifdef OVL_WIDTH_COVER_EN
    , .cov_count(cov_a)
`endif
  );

  ovl_width_multi #(.NUM_CH(1), .MIN_CKS(2), .MAX_CKS(2)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .test_expr(te_b),
    .fire_min(fmin_b), .fire_max(fmax_b), .fire(fire_b)
`ifdef OVL_WIDTH_COVER_EN
    , .cov_count(cov_b)
`endif
  );

  ovl_width_multi #(.NUM_CH(1), .MIN_CKS(0), .MAX_CKS(0)) dut_c (
    .clock(clock), .reset(reset), .enable(enable), .test_expr(te_c),
    .fire_min(fmin_c), .fire_max(fmax_c), .fire(fire_c)
`ifdef OVL_WIDTH_COVER_EN
    , .cov_count(cov_c)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. Channels 0..3 are dut_a, channel 4 is dut_b and
  // channel 5 is dut_c.
  int mn_cfg [6] = '{2, 2, 2, 2, 2, 0};
  int mx_cfg [6] = '{3, 3, 3, 3, 2, 0};
  int m_len  [6];
  bit m_act  [6];
  bit e_min  [6];
  bit e_max  [6];
  bit e_leg  [6];
  int cov_m  [3];

  function automatic void ch_model(input int mn, input int mx, input bit en, input bit te,
                                   inout int len, inout bit act,
                                   output bit emin, output bit emax, output bit eleg);
    emin = 1'b0; emax = 1'b0; eleg = 1'b0;
    if (!en) begin
      act = 1'b0; len = 0;
    end else if (act) begin
      if (te) begin
        len++;
        if (mx != 0 && len == mx + 1) emax = 1'b1;
      end else begin
        emin = (mn != 0 && len < mn);
        eleg = !emin && (mx == 0 || len <= mx);
        act = 1'b0; len = 0;
      end
    end else if (te) begin
      act = 1'b1; len = 1;
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 6; i++) begin
      m_len[i] = 0; m_act[i] = 1'b0;
      e_min[i] = 1'b0; e_max[i] = 1'b0; e_leg[i] = 1'b0;
    end
    for (int i = 0; i < 3; i++) cov_m[i] = 0;
  endfunction

  function automatic int sat_add(input int a, input int b);
    return (a + b > 65535) ? 65535 : a + b;
  endfunction

  // Drive one sample, advance one edge, then compare every output with the model.
  task automatic step(input bit en, input logic [3:0] ta, input bit tb1, input bit tc1);
    logic [5:0] te_all;
    logic [3:0] xmin_a, xmax_a;
    int         na;
    enable = en; te_a = ta; te_b = tb1; te_c = tc1;
    te_all = {tc1, tb1, ta};
    for (int i = 0; i < 6; i++)
      ch_model(mn_cfg[i], mx_cfg[i], en, te_all[i], m_len[i], m_act[i], e_min[i], e_max[i], e_leg[i]);
    na = 0;
    for (int i = 0; i < 4; i++) begin
      xmin_a[i] = e_min[i]; xmax_a[i] = e_max[i]; na += int'(e_leg[i]);
    end
    cov_m[0] = sat_add(cov_m[0], na);
    cov_m[1] = sat_add(cov_m[1], int'(e_leg[4]));
    cov_m[2] = sat_add(cov_m[2], int'(e_leg[5]));
    @(posedge clock);
    #1;
    check("a.fire_min", fmin_a, xmin_a);
    check("a.fire_max", fmax_a, xmax_a);
    check("a.fire", fire_a, {COV & (na != 0), 1'b0, |(xmin_a | xmax_a)});
    check("b.fire_min", fmin_b, e_min[4]);
    check("b.fire_max", fmax_b, e_max[4]);
    check("b.fire", fire_b, {COV & e_leg[4], 1'b0, e_min[4] | e_max[4]});
    check("c.fire_min", fmin_c, e_min[5]);
    check("c.fire_max", fmax_c, e_max[5]);
    check("c.fire", fire_c, {COV & e_leg[5], 1'b0, e_min[5] | e_max[5]});
`ifdef OVL_WIDTH_COVER_EN
    check("a.cov_count", cov_a, cov_m[0]);
    check("b.cov_count", cov_b, cov_m[1]);
    check("c.cov_count", cov_c, cov_m[2]);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".a"}, {fire_a, fmin_a, fmax_a}, 0);
    check({tag, ".b"}, {fire_b, fmin_b, fmax_b}, 0);
    check({tag, ".c"}, {fire_c, fmin_c, fmax_c}, 0);
`ifdef OVL_WIDTH_COVER_EN
    check({tag, ".cov"}, {cov_a, cov_b, cov_c}, 0);
`endif
  endtask

  // Assert reset in the middle of a cycle, hold it across two edges with
  // the given inputs, then release it away from any edge.
  task automatic do_reset(input logic [3:0] ta, input bit tb1);
    te_a = ta; te_b = tb1; te_c = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("rst.async");
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("rst.hold");
    reset = 1'b1;
  endtask

  typedef struct {
    bit         en;
    logic [3:0] te;
    logic [3:0] emin;
    logic [3:0] emax;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit en, input logic [3:0] te,
                              input logic [3:0] emin, input logic [3:0] emax);
    vec_t v;
    v.en = en; v.te = te; v.emin = emin; v.emax = emax;
    return v;
  endfunction

  initial begin
    int nmax;
`ifdef OVL_WIDTH_COVER_EN
    int cov_before;
`endif

    // dut_a vectors: {enable, test_expr, expected fire_min, expected fire_max}
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000));
    vecs.push_back(mk(1, 4'b0101, 4'b0000, 4'b0000)); // ch0, ch2 rise
    vecs.push_back(mk(1, 4'b0100, 4'b0001, 4'b0000)); // ch0 width 1 < 2
    vecs.push_back(mk(1, 4'b0100, 4'b0000, 4'b0000));
    vecs.push_back(mk(1, 4'b0100, 4'b0000, 4'b0100)); // ch2 past 3
    vecs.push_back(mk(1, 4'b0100, 4'b0000, 4'b0000));
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000)); // ch2 ends at 5, no min
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000));
    vecs.push_back(mk(1, 4'b0010, 4'b0000, 4'b0000)); // ch1 rise
    vecs.push_back(mk(0, 4'b0010, 4'b0000, 4'b0000)); // disabled mid-pulse
    vecs.push_back(mk(1, 4'b0010, 4'b0000, 4'b0000)); // restart at 1
    vecs.push_back(mk(1, 4'b0010, 4'b0000, 4'b0000));
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000)); // width 2 legal
    vecs.push_back(mk(1, 4'b0010, 4'b0000, 4'b0000));
    vecs.push_back(mk(1, 4'b0000, 4'b0010, 4'b0000));
    vecs.push_back(mk(1, 4'b1111, 4'b0000, 4'b0000));
    vecs.push_back(mk(1, 4'b0000, 4'b1111, 4'b0000)); // all channels at once
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000));
    vecs.push_back(mk(1, 4'b0001, 4'b0000, 4'b0000));
    vecs.push_back(mk(1, 4'b0001, 4'b0000, 4'b0000));
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000)); // width 2 ends
    vecs.push_back(mk(1, 4'b0001, 4'b0000, 4'b0000)); // immediate re-rise
    vecs.push_back(mk(1, 4'b0000, 4'b0001, 4'b0000)); // second pulse width 1
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000));

    // Reset state
    reset = 1'b0; enable = 1'b0; te_a = '0; te_b = '0; te_c = '0;
    model_clear();
    #1;
    check_all_zero("reset_state");
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Table vectors on dut_a
    foreach (vecs[k]) begin
      step(vecs[k].en, vecs[k].te, 1'b0, 1'b0);
      check("tbl.fire_min", fmin_a, vecs[k].emin);
      check("tbl.fire_max", fmax_a, vecs[k].emax);
      check("tbl.fire0", fire_a[0], |(vecs[k].emin | vecs[k].emax));
    end

    // Long pulse on dut_a ch3: max fires exactly once, with no wrap
    nmax = 0;
    repeat (20) begin
      step(1'b1, 4'b1000, 1'b0, 1'b0);
      nmax += int'(fmax_a[3]);
    end
    check("a.long_max_once", nmax, 1);
    step(1'b1, 4'b0000, 1'b0, 1'b0);
    check("a.long_no_min", fmin_a, 4'b0000);

    // dut_b MIN=MAX=2: high for 3 samples -> fire_max after the 3rd only
    step(1'b1, 4'b0000, 1'b1, 1'b0);
    step(1'b1, 4'b0000, 1'b1, 1'b0);
    check("b.w3_early", fmax_b, 1'b0);
    step(1'b1, 4'b0000, 1'b1, 1'b0);
    check("b.w3_max", fmax_b, 1'b1);
    check("b.w3_fire0", fire_b[0], 1'b1);
    step(1'b1, 4'b0000, 1'b0, 1'b0);
    check("b.w3_max_drop", fmax_b, 1'b0);
    check("b.w3_no_min", fmin_b, 1'b0);
    // 1-sample pulse -> fire_min for one cycle
    step(1'b1, 4'b0000, 1'b1, 1'b0);
    step(1'b1, 4'b0000, 1'b0, 1'b0);
    check("b.w1_min", fmin_b, 1'b1);
    step(1'b1, 4'b0000, 1'b0, 1'b0);
    check("b.w1_min_drop", fmin_b, 1'b0);
    // 2-sample pulse -> legal
    step(1'b1, 4'b0000, 1'b1, 1'b0);
    step(1'b1, 4'b0000, 1'b1, 1'b0);
    step(1'b1, 4'b0000, 1'b0, 1'b0);
    check("b.w2_legal", {fire_b, fmin_b, fmax_b}, {COV, 1'b0, 1'b0, 1'b0, 1'b0});

    // Disabled with arbitrary toggling -> all fire bits stay low
    repeat (30) begin
      step(1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check("dis.quiet", {fire_a, fmin_a, fmax_a, fire_b, fire_c}, 0);
    end

    // dut_c MIN=MAX=0: 300-sample pulse, never fires, one covered pulse
`ifdef OVL_WIDTH_COVER_EN
    cov_before = int'(cov_c);
`endif
    repeat (300) step(1'b1, 4'b0000, 1'b0, 1'b1);
    step(1'b1, 4'b0000, 1'b0, 1'b0);
    check("c.long_quiet", {fire_c[1:0], fmin_c, fmax_c}, 0);
`ifdef OVL_WIDTH_COVER_EN
    check("c.cov_inc", cov_c, cov_before + 1);
`endif

    // Async reset during the 2nd cycle of a pulse on dut_b
    step(1'b1, 4'b0000, 1'b1, 1'b0);
    do_reset(4'b0000, 1'b1);
    repeat (3) begin
      step(1'b1, 4'b0000, 1'b0, 1'b0);
      check("rst.no_fire_b", {fire_b, fmin_b, fmax_b}, 0);
    end

    // Input held high through reset counts as a new pulse from the first edge
    do_reset(4'b0001, 1'b0);
    step(1'b1, 4'b0001, 1'b0, 1'b0);
    check("rst.rise_no_fire", fmin_a, 4'b0000);
    step(1'b1, 4'b0000, 1'b0, 1'b0);
    check("rst.rise_width1", fmin_a, 4'b0001);

    // Randomized traffic against the model
    repeat (400) begin
      step($urandom_range(0, 15) != 0,
           {1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0)},
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
